// File: rtl/gray_counter_param.sv
// Parametrised Gray-code counter with up/down, load, wrap/saturate and sticky flags.
// Output is the registered Gray code of the next binary count.
module gray_counter_param #(
    parameter int                 WIDTH    = 3,
    parameter int                 SATURATE = 0,
    parameter logic [WIDTH-1:0]   INIT     = '0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    input  logic             Up,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadVal,
    input  logic             ClrFlag,
    output logic [WIDTH-1:0] Output,
    output logic [WIDTH-1:0] Binary,
    output logic             Overflow,
    output logic             Underflow,
    output logic             Wrap
);

    localparam logic [WIDTH-1:0] MAX_VAL   = '1;
    localparam logic [WIDTH-1:0] ZERO_VAL  = '0;
    localparam logic [WIDTH-1:0] ONE_VAL   = WIDTH'(1);
    localparam logic [WIDTH-1:0] INIT_GRAY = INIT ^ (INIT >> 1);
    localparam bit               SAT_MODE  = (SATURATE != 0);

    logic [WIDTH-1:0] bin_next;
    logic [WIDTH-1:0] gray_next;
    logic             ovf_next;
    logic             unf_next;
    logic             wrap_next;

    // Next count and flags: load beats enable, a boundary set beats a flag clear.
    always_comb begin
        bin_next  = Binary;
        ovf_next  = ClrFlag ? 1'b0 : Overflow;
        unf_next  = ClrFlag ? 1'b0 : Underflow;
        wrap_next = 1'b0;
        if (Load) begin
            bin_next = LoadVal;
        end else if (En) begin
            if (Up) begin
                if (Binary == MAX_VAL) begin
                    ovf_next = 1'b1;
                    if (!SAT_MODE) begin
                        bin_next  = ZERO_VAL;
                        wrap_next = 1'b1;
                    end
                end else begin
                    bin_next = Binary + ONE_VAL;
                end
            end else begin
                if (Binary == ZERO_VAL) begin
                    unf_next = 1'b1;
                    if (!SAT_MODE) begin
                        bin_next  = MAX_VAL;
                        wrap_next = 1'b1;
                    end
                end else begin
                    bin_next = Binary - ONE_VAL;
                end
            end
        end
        gray_next = bin_next ^ (bin_next >> 1);
    end

    // State register; Gray code is registered alongside the binary count.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Binary    <= INIT;
            Output    <= INIT_GRAY;
            Overflow  <= 1'b0;
            Underflow <= 1'b0;
            Wrap      <= 1'b0;
        end else begin
            Binary    <= bin_next;
            Output    <= gray_next;
            Overflow  <= ovf_next;
            Underflow <= unf_next;
            Wrap      <= wrap_next;
        end
    end

endmodule

// File: tb/tb_gray_counter_param.sv
// Scoreboard bench for gray_counter_param: three configurations driven in lockstep,
// expected results queued by the driver and popped by an independent monitor.
module tb_gray_counter_param;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       En = 1'b0;
    logic       Up = 1'b0;
    logic       Load = 1'b0;
    logic [7:0] LoadVal = '0;
    logic       ClrFlag = 1'b0;

    logic [2:0] gray0, bin0;
    logic [2:0] gray1, bin1;
    logic [4:0] gray2, bin2;
    logic       ovf0, unf0, wrap0;
    logic       ovf1, unf1, wrap1;
    logic       ovf2, unf2, wrap2;

    int errors = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    gray_counter_param #(.WIDTH(3), .SATURATE(0), .INIT(3'd0)) dut_wrap (
        .Clk(Clk), .Reset(Reset), .En(En), .Up(Up), .Load(Load),
        .LoadVal(LoadVal[2:0]), .ClrFlag(ClrFlag),
        .Output(gray0), .Binary(bin0), .Overflow(ovf0),
        .Underflow(unf0), .Wrap(wrap0)
    );

    gray_counter_param #(.WIDTH(3), .SATURATE(1), .INIT(3'd0)) dut_sat (
        .Clk(Clk), .Reset(Reset), .En(En), .Up(Up), .Load(Load),
        .LoadVal(LoadVal[2:0]), .ClrFlag(ClrFlag),
        .Output(gray1), .Binary(bin1), .Overflow(ovf1),
        .Underflow(unf1), .Wrap(wrap1)
    );

    gray_counter_param #(.WIDTH(5), .SATURATE(0), .INIT(5'd17)) dut_wide (
        .Clk(Clk), .Reset(Reset), .En(En), .Up(Up), .Load(Load),
        .LoadVal(LoadVal[4:0]), .ClrFlag(ClrFlag),
        .Output(gray2), .Binary(bin2), .Overflow(ovf2),
        .Underflow(unf2), .Wrap(wrap2)
    );

    // Reference model: plain integer count per configuration.
    int cfg_w[3]    = '{3, 3, 5};
    int cfg_sat[3]  = '{0, 1, 0};
    int cfg_init[3] = '{0, 0, 17};
    int m_bin[3];
    bit m_ovf[3];
    bit m_unf[3];

    int q0[$];
    int q1[$];
    int q2[$];

    function automatic int pack_exp(int b, bit o, bit u, bit w);
        int g;
        g = b ^ (b >> 1);
        return b | (g << 8) | (int'(o) << 16) | (int'(u) << 17) | (int'(w) << 18);
    endfunction

    task automatic step(input bit r, input bit e, input bit u,
                        input bit l, input int lv, input bit c);
        int res[3];
        @(negedge Clk);
        Reset   = r;
        En      = e;
        Up      = u;
        Load    = l;
        LoadVal = lv[7:0];
        ClrFlag = c;
        for (int i = 0; i < 3; i++) begin
            int top;
            bit wr;
            top = (1 << cfg_w[i]) - 1;
            wr  = 1'b0;
            if (r) begin
                m_bin[i] = cfg_init[i];
                m_ovf[i] = 1'b0;
                m_unf[i] = 1'b0;
            end else begin
                if (c) begin
                    m_ovf[i] = 1'b0;
                    m_unf[i] = 1'b0;
                end
                if (l) begin
                    m_bin[i] = lv & top;
                end else if (e && u) begin
                    if (m_bin[i] == top) begin
                        m_ovf[i] = 1'b1;
                        if (cfg_sat[i] == 0) begin
                            m_bin[i] = 0;
                            wr = 1'b1;
                        end
                    end else begin
                        m_bin[i] = m_bin[i] + 1;
                    end
                end else if (e) begin
                    if (m_bin[i] == 0) begin
                        m_unf[i] = 1'b1;
                        if (cfg_sat[i] == 0) begin
                            m_bin[i] = top;
                            wr = 1'b1;
                        end
                    end else begin
                        m_bin[i] = m_bin[i] - 1;
                    end
                end
            end
            res[i] = pack_exp(m_bin[i], m_ovf[i], m_unf[i], wr);
        end
        q0.push_back(res[0]);
        q1.push_back(res[1]);
        q2.push_back(res[2]);
    endtask

    task automatic compare(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got bin=%0d gray=%0h ovf=%0d unf=%0d wrap=%0d, want bin=%0d gray=%0h ovf=%0d unf=%0d wrap=%0d",
                     name, $time, act & 255, (act >> 8) & 255, (act >> 16) & 1,
                     (act >> 17) & 1, (act >> 18) & 1, exp & 255, (exp >> 8) & 255,
                     (exp >> 16) & 1, (exp >> 17) & 1, (exp >> 18) & 1);
        end
    endtask

    // Monitor: outputs are valid every cycle, sampled 1 time unit after the edge.
    initial begin
        forever begin
            @(posedge Clk);
            #1;
            if (q0.size() > 0) begin
                int a0, a1, a2;
                a0 = int'(bin0) | (int'(gray0) << 8) | (int'(ovf0) << 16)
                   | (int'(unf0) << 17) | (int'(wrap0) << 18);
                a1 = int'(bin1) | (int'(gray1) << 8) | (int'(ovf1) << 16)
                   | (int'(unf1) << 17) | (int'(wrap1) << 18);
                a2 = int'(bin2) | (int'(gray2) << 8) | (int'(ovf2) << 16)
                   | (int'(unf2) << 17) | (int'(wrap2) << 18);
                compare("wrap_w3", a0, q0.pop_front());
                compare("sat_w3", a1, q1.pop_front());
                compare("wrap_w5_init17", a2, q2.pop_front());
            end
        end
    end

    initial begin
        // 1: count up through the rollover
        step(1, 0, 0, 0, 0, 0);
        repeat (9) step(0, 1, 1, 0, 0, 0);
        // 2: enable toggled every two cycles
        step(1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 20; k++) step(0, ((k / 2) % 2) == 0, 1, 0, 0, 0);
        // 3: count down from reset, then clear flags
        step(1, 0, 0, 0, 0, 0);
        repeat (2) step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0);
        // 4: load beats enable; reset beats load
        step(0, 1, 1, 1, 5, 0);
        step(1, 1, 1, 1, 5, 0);
        // 5: hold at the top in saturate mode
        step(1, 0, 0, 0, 0, 0);
        repeat (10) step(0, 1, 1, 0, 0, 0);
        // 6: boundary step together with a flag clear
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 31, 0);
        step(0, 1, 1, 0, 0, 1);
        step(0, 1, 0, 1, 0, 1);
        step(0, 1, 0, 0, 0, 1);
        // random traffic
        for (int k = 0; k < 400; k++) begin
            step($urandom_range(0, 49) == 0, ($urandom % 4) != 0, $urandom % 2,
                 $urandom_range(0, 9) == 0, int'($urandom % 256),
                 $urandom_range(0, 7) == 0);
        end
        for (int k = 0; k < 10 && q0.size() > 0; k++) @(posedge Clk);
        #2;
        if (q0.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", q0.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
